thumb_decode_stage: RTL and testbench

//  Registered, handshaked decode stage for the 16-bit Thumb subset; successor of the combinational decoder.

---
 rtl/thumb_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_thumb_decode_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_decode_stage.sv
// thumb_decode_stage: registered valid/ready decoder for the 16-bit Thumb subset.
// A two-state prefix FSM stitches the two BL halfwords into one bundle.
module thumb_decode_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        r_addr1,
    output logic [3:0]        r_addr2,
    output logic [3:0]        w_addr,
    output logic              we,
    output logic [2:0]        alu_op,
    output logic [1:0]        shifter_op,
    output logic              use_const,
    output logic              move_const,
    output logic              move,
    output logic              l_s,
    output logic              b,
    output logic              b_add,
    output logic              link,
    output logic [3:0]        cond,
    output logic [DATA_W-1:0] const_a,
    output logic [DATA_W-1:0] const_b,
    output logic              undef,
    output logic [CNT_W-1:0]  dec_count
);

    typedef struct packed {
        logic [3:0]        ra1;
        logic [3:0]        ra2;
        logic [3:0]        wa;
        logic              we;
        logic [2:0]        alu;
        logic [1:0]        sh;
        logic              uc;
        logic              mc;
        logic              mv;
        logic              ls;
        logic              br;
        logic              ba;
        logic              lk;
        logic [3:0]        cc;
        logic [DATA_W-1:0] ca;
        logic [DATA_W-1:0] cb;
        logic              ud;
    } bundle_t;

    typedef enum logic {
        S_IDLE,
        S_BL_WAIT
    } state_t;

    localparam logic [3:0] PC = 4'd15;
    localparam logic [3:0] SP = 4'd13;
    localparam logic [3:0] AL = 4'b1110;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [10:0]      r_hi;
    logic             r_valid;
    bundle_t          r_bun;
    bundle_t          w_dec;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_prefix;
    logic w_suffix;
    logic w_latch;
    logic w_emit;

    logic w_is_addsub;
    logic w_is_movs;
    logic w_is_dp;
    logic w_is_mov;
    logic w_is_bx;
    logic w_is_ldst;
    logic w_is_sp;
    logic w_is_nop;
    logic w_is_bcc;
    logic w_is_b;

    logic [3:0]        w_op4;
    logic [DATA_W-1:0] w_bcc_off;
    logic [DATA_W-1:0] w_b_off;
    logic [DATA_W-1:0] w_bl_off;

    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_prefix = instruction[15:11] == 5'b11110;
    assign w_suffix = instruction[15:11] == 5'b11111;

    assign w_is_addsub = instruction[15:11] == 5'b00011;
    assign w_is_movs   = instruction[15:11] == 5'b00100;
    assign w_is_dp     = instruction[15:10] == 6'b010000;
    assign w_is_mov    = instruction[15:8] == 8'h46;
    assign w_is_bx     = (instruction[15:7] == 9'b010001110)
                      && (instruction[2:0] == 3'b000);
    assign w_is_ldst   = instruction[15:12] == 4'b0110;
    assign w_is_sp     = instruction[15:8] == 8'hB0;
    assign w_is_nop    = instruction == 16'hBF00;
    assign w_is_bcc    = (instruction[15:12] == 4'hD)
                      && (instruction[11:9] != 3'b111);
    assign w_is_b      = instruction[15:11] == 5'b11100;

    assign w_op4     = instruction[9:6];
    assign w_bcc_off = {{(DATA_W-9){instruction[7]}},
                        instruction[7:0], 1'b0};
    assign w_b_off   = {{(DATA_W-12){instruction[10]}},
                        instruction[10:0], 1'b0};
    assign w_bl_off  = {{(DATA_W-23){r_hi[10]}},
                        r_hi, instruction[10:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) r_hi <= instruction[10:0];
        end
    end

    // A prefix is consumed without emitting; anything after it emits.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_emit      = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_prefix) begin
                        w_state_nxt = S_BL_WAIT;
                        w_latch     = 1'b1;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                S_BL_WAIT: begin
                    w_state_nxt = S_IDLE;
                    w_emit      = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_dec = '0;
        if (r_state == S_BL_WAIT) begin
            if (w_suffix) begin
                w_dec.lk  = 1'b1;
                w_dec.ba  = 1'b1;
                w_dec.ra1 = PC;
                w_dec.wa  = PC;
                w_dec.cc  = AL;
                w_dec.ca  = w_bl_off;
                w_dec.cb  = DATA_W'(1);
            end else begin
                w_dec.ud = 1'b1;
            end
        end else begin
            unique case (1'b1)
                w_is_addsub: begin
                    w_dec.ra1 = {1'b0, instruction[5:3]};
                    w_dec.wa  = {1'b0, instruction[2:0]};
                    w_dec.we  = 1'b1;
                    w_dec.alu = instruction[9] ? 3'b010 : 3'b001;
                    if (instruction[10]) begin
                        w_dec.uc = 1'b1;
                        w_dec.cb = DATA_W'(instruction[8:6]);
                    end else begin
                        w_dec.ra2 = {1'b0, instruction[8:6]};
                    end
                end
                w_is_movs: begin
                    w_dec.mc = 1'b1;
                    w_dec.ca = DATA_W'(instruction[7:0]);
                    w_dec.wa = {1'b0, instruction[10:8]};
                    w_dec.we = 1'b1;
                end
                w_is_dp: begin
                    w_dec.ra1 = {1'b0, instruction[2:0]};
                    w_dec.wa  = {1'b0, instruction[2:0]};
                    w_dec.ra2 = {1'b0, instruction[5:3]};
                    w_dec.we  = 1'b1;
                    unique case (w_op4)
                        4'h0: w_dec.alu = 3'b011;
                        4'h1: w_dec.alu = 3'b100;
                        4'h2: w_dec.sh  = 2'b00;
                        4'h3: w_dec.sh  = 2'b01;
                        4'h4: w_dec.sh  = 2'b10;
                        4'h7: w_dec.sh  = 2'b11;
                        4'hA: begin
                            w_dec.alu = 3'b111;
                            w_dec.we  = 1'b0;
                        end
                        4'hC: w_dec.alu = 3'b101;
                        4'hF: w_dec.alu = 3'b110;
                        default: begin
                            w_dec    = '0;
                            w_dec.ud = 1'b1;
                        end
                    endcase
                end
                w_is_mov: begin
                    w_dec.mv  = 1'b1;
                    w_dec.ra1 = instruction[6:3];
                    w_dec.wa  = {instruction[7], instruction[2:0]};
                    w_dec.we  = 1'b1;
                end
                w_is_bx: begin
                    w_dec.br  = 1'b1;
                    w_dec.ra1 = instruction[6:3];
                    w_dec.wa  = PC;
                    w_dec.cc  = AL;
                end
                w_is_ldst: begin
                    w_dec.ls  = 1'b1;
                    w_dec.ra1 = {1'b0, instruction[5:3]};
                    w_dec.cb  = DATA_W'({instruction[10:6], 2'b00});
                    if (instruction[11]) begin
                        w_dec.wa = {1'b0, instruction[2:0]};
                        w_dec.we = 1'b1;
                    end else begin
                        w_dec.ra2 = {1'b0, instruction[2:0]};
                    end
                end
                w_is_sp: begin
                    w_dec.ra1 = SP;
                    w_dec.wa  = SP;
                    w_dec.we  = 1'b1;
                    w_dec.uc  = 1'b1;
                    w_dec.alu = instruction[7] ? 3'b010 : 3'b001;
                    w_dec.cb  = DATA_W'({instruction[6:0], 2'b00});
                end
                w_is_nop: begin
                    w_dec = '0;
                end
                w_is_bcc: begin
                    w_dec.ba  = 1'b1;
                    w_dec.ra1 = PC;
                    w_dec.wa  = PC;
                    w_dec.cc  = instruction[11:8];
                    w_dec.ca  = w_bcc_off;
                end
                w_is_b: begin
                    w_dec.ba  = 1'b1;
                    w_dec.ra1 = PC;
                    w_dec.wa  = PC;
                    w_dec.cc  = AL;
                    w_dec.ca  = w_b_off;
                end
                default: begin
                    w_dec.ud = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_bun   <= '0;
            r_cnt   <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_emit) begin
                r_valid <= 1'b1;
                r_bun   <= w_dec;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (!flush && r_valid && out_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign r_addr1    = r_bun.ra1;
    assign r_addr2    = r_bun.ra2;
    assign w_addr     = r_bun.wa;
    assign we         = r_bun.we;
    assign alu_op     = r_bun.alu;
    assign shifter_op = r_bun.sh;
    assign use_const  = r_bun.uc;
    assign move_const = r_bun.mc;
    assign move       = r_bun.mv;
    assign l_s        = r_bun.ls;
    assign b          = r_bun.br;
    assign b_add      = r_bun.ba;
    assign link       = r_bun.lk;
    assign cond       = r_bun.cc;
    assign const_a    = r_bun.ca;
    assign const_b    = r_bun.cb;
    assign undef      = r_bun.ud;
    assign dec_count  = r_cnt;

endmodule

// File: tb/tb_thumb_decode_stage.sv
// tb_thumb_decode_stage: table vectors, hand sequences for BL/hold/flush/reset/wrap,
// then randomized traffic against a behavioural model.
module tb_thumb_decode_stage;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [3:0]    r1;
        logic [3:0]    r2;
        logic [3:0]    w;
        logic          we;
        logic [2:0]    alu;
        logic [1:0]    sh;
        logic          uc;
        logic          mc;
        logic          mv;
        logic          ls;
        logic          b;
        logic          ba;
        logic          lk;
        logic [3:0]    cond;
        logic [DW-1:0] ca;
        logic [DW-1:0] cb;
        logic          ud;
    } bun_t;

    typedef struct {
        logic [15:0] ins;
        bun_t        exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [15:0]   instruction = 16'h0;
    logic          in_ready, out_valid, we, use_const, move_const;
    logic          move, l_s, b, b_add, link, undef;
    logic [3:0]    r_addr1, r_addr2, w_addr, cond;
    logic [2:0]    alu_op;
    logic [1:0]    shifter_op;
    logic [DW-1:0] const_a, const_b;
    logic [CW-1:0] dec_count;

    int n_cmp = 0;
    int n_bad = 0;

    thumb_decode_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .w_addr(w_addr),
        .we(we), .alu_op(alu_op), .shifter_op(shifter_op),
        .use_const(use_const), .move_const(move_const),
        .move(move), .l_s(l_s), .b(b), .b_add(b_add), .link(link),
        .cond(cond), .const_a(const_a), .const_b(const_b),
        .undef(undef), .dec_count(dec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bun_t dut_bun();
        bun_t a;
        a = {r_addr1, r_addr2, w_addr, we, alu_op, shifter_op,
             use_const, move_const, move, l_s, b, b_add, link,
             cond, const_a, const_b, undef};
        return a;
    endfunction

    // Reference decode, written from the instruction-set rules.
    function automatic bun_t ref_dec(bit wt, logic [10:0] hi,
                                     logic [15:0] ins);
        bun_t e;
        int   v;
        e = '0;
        if (wt) begin
            if (ins[15:11] == 5'b11111) begin
                e.lk = 1; e.ba = 1; e.r1 = 15; e.w = 15; e.cond = 4'hE;
                v = int'({hi, ins[10:0]});
                if (v >= (1 << 21)) v -= (1 << 22);
                e.ca = DW'(v * 2);
                e.cb = 1;
            end else e.ud = 1;
            return e;
        end
        if (ins[15:11] == 5'b00011) begin
            e.r1 = {1'b0, ins[5:3]}; e.w = {1'b0, ins[2:0]}; e.we = 1;
            e.alu = ins[9] ? 3'd2 : 3'd1;
            if (ins[10]) begin e.uc = 1; e.cb = DW'(ins[8:6]); end
            else e.r2 = {1'b0, ins[8:6]};
        end else if (ins[15:11] == 5'b00100) begin
            e.mc = 1; e.ca = DW'(ins[7:0]);
            e.w = {1'b0, ins[10:8]}; e.we = 1;
        end else if (ins[15:10] == 6'b010000) begin
            e.r1 = {1'b0, ins[2:0]}; e.w = e.r1;
            e.r2 = {1'b0, ins[5:3]}; e.we = 1;
            case (int'(ins[9:6]))
                0: e.alu = 3; 1: e.alu = 4;
                2: e.sh = 0; 3: e.sh = 1; 4: e.sh = 2; 7: e.sh = 3;
                10: begin e.alu = 7; e.we = 0; end
                12: e.alu = 5; 15: e.alu = 6;
                default: begin e = '0; e.ud = 1; end
            endcase
        end else if (ins[15:8] == 8'h46) begin
            e.mv = 1; e.r1 = ins[6:3]; e.w = {ins[7], ins[2:0]}; e.we = 1;
        end else if (ins[15:7] == 9'b010001110 && ins[2:0] == 0) begin
            e.b = 1; e.r1 = ins[6:3]; e.w = 15; e.cond = 4'hE;
        end else if (ins[15:12] == 4'b0110) begin
            e.ls = 1; e.r1 = {1'b0, ins[5:3]};
            e.cb = DW'(int'(ins[10:6]) * 4);
            if (ins[11]) begin e.w = {1'b0, ins[2:0]}; e.we = 1; end
            else e.r2 = {1'b0, ins[2:0]};
        end else if (ins[15:8] == 8'hB0) begin
            e.r1 = 13; e.w = 13; e.we = 1; e.uc = 1;
            e.alu = ins[7] ? 3'd2 : 3'd1;
            e.cb = DW'(int'(ins[6:0]) * 4);
        end else if (ins == 16'hBF00) begin
            e = '0;
        end else if (ins[15:12] == 4'hD && ins[11:9] != 3'b111) begin
            e.ba = 1; e.r1 = 15; e.w = 15; e.cond = ins[11:8];
            v = int'(ins[7:0]);
            if (v >= 128) v -= 256;
            e.ca = DW'(v * 2);
        end else if (ins[15:11] == 5'b11100) begin
            e.ba = 1; e.r1 = 15; e.w = 15; e.cond = 4'hE;
            v = int'(ins[10:0]);
            if (v >= 1024) v -= 2048;
            e.ca = DW'(v * 2);
        end else e.ud = 1;
        return e;
    endfunction

    localparam logic [7:0] HB [24] = '{
        8'h18, 8'h1A, 8'h1C, 8'h1F, 8'h20, 8'h27, 8'h40, 8'h41,
        8'h42, 8'h43, 8'h45, 8'h46, 8'h60, 8'h6F, 8'hB0, 8'hB8,
        8'hD0, 8'hDE, 8'hDF, 8'hE3, 8'hE7, 8'hF0, 8'hF8, 8'hFF
    };

    function automatic logic [15:0] rnd_ins();
        int k;
        k = $urandom_range(0, 29);
        if (k < 24) return {HB[k], 8'($urandom)};
        if (k < 26) return {8'h47, 1'b0, 4'($urandom), 3'b000};
        if (k < 27) return 16'hBF00;
        return 16'($urandom);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; instruction = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(logic [15:0] ins);
        @(negedge clk);
        in_valid = 1'b1;
        instruction = ins;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    vec_t tbl[$];
    bun_t e;
    bun_t m_b;
    bit   m_ov, m_wait, exp_rdy;
    logic [10:0] m_hi;
    logic [CW-1:0] m_cnt;

    initial begin
        e = '0; e.r1 = 1; e.r2 = 2; e.we = 1; e.alu = 1;
        tbl.push_back('{16'h1888, e});
        e = '0; e.mc = 1; e.ca = 5; e.w = 3; e.we = 1;
        tbl.push_back('{16'h2305, e});
        e = '0; e.ba = 1; e.r1 = 15; e.w = 15; e.cond = 4'h1;
        e.ca = 32'hFFFF_FFFC;
        tbl.push_back('{16'hD1FE, e});
        e = '0; e.r2 = 1; e.we = 1; e.alu = 3;
        tbl.push_back('{16'h4008, e});
        e = '0; e.r1 = 1; e.w = 1; e.alu = 7;
        tbl.push_back('{16'h4281, e});
        e = '0; e.b = 1; e.r1 = 14; e.w = 15; e.cond = 4'hE;
        tbl.push_back('{16'h4770, e});
        e = '0;
        tbl.push_back('{16'hBF00, e});
        e = '0; e.ls = 1; e.r1 = 1; e.we = 1; e.cb = 4;
        tbl.push_back('{16'h6848, e});
        e = '0; e.ba = 1; e.r1 = 15; e.w = 15; e.cond = 4'hE;
        e.ca = 32'hFFFF_FFFC;
        tbl.push_back('{16'hE7FE, e});
        e = '0; e.r1 = 13; e.w = 13; e.uc = 1; e.cb = 8;
        e.alu = 2; e.we = 1;
        tbl.push_back('{16'hB082, e});
        e = '0; e.ud = 1;
        tbl.push_back('{16'hDE00, e});
        tbl.push_back('{16'hFFFF, e});
        tbl.push_back('{16'h4200, e});
        e = '0; e.r1 = 1; e.w = 2; e.we = 1; e.alu = 1;
        e.uc = 1; e.cb = 5;
        tbl.push_back('{16'h1D4A, e});
        e = '0; e.r1 = 1; e.w = 1; e.r2 = 2; e.we = 1; e.sh = 1;
        tbl.push_back('{16'h40D1, e});
        e = '0; e.mv = 1; e.r1 = 8; e.we = 1;
        tbl.push_back('{16'h4640, e});
        e = '0; e.ls = 1; e.r1 = 2;
        tbl.push_back('{16'h6010, e});

        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", dec_count, 0);
        chk("rst_bundle", dut_bun(), 0);
        chk("rst_in_ready", in_ready, 1);

        foreach (tbl[i]) begin
            send(tbl[i].ins);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_%h", i, tbl[i].ins),
                dut_bun(), tbl[i].exp);
        end

        // BL pair produces exactly one bundle
        do_reset();
        send(16'hF000);
        chk("bl_prefix_silent", out_valid, 0);
        send(16'hF802);
        e = '0; e.lk = 1; e.ba = 1; e.r1 = 15; e.w = 15;
        e.cond = 4'hE; e.ca = 4; e.cb = 1;
        chk("bl_valid", out_valid, 1);
        chk("bl_bundle", dut_bun(), e);
        chk("bl_cnt_before", dec_count, 0);
        @(posedge clk); #1;
        chk("bl_cnt_after", dec_count, 1);
        chk("bl_drained", out_valid, 0);

        // broken BL pair
        do_reset();
        send(16'hF000);
        send(16'h1888);
        e = '0; e.ud = 1;
        chk("bl_broken", dut_bun(), e);
        send(16'h1888);
        chk("after_broken", dut_bun(), tbl[0].exp);

        // backpressure hold
        do_reset();
        out_ready = 1'b0;
        send(16'h2305);
        @(negedge clk);
        in_valid = 1'b1; instruction = 16'h1888;
        #1 chk("hold_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_bundle", dut_bun(), tbl[1].exp);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_bundle", dut_bun(), tbl[0].exp);
        chk("release_cnt", dec_count, 1);

        // flush while a BL prefix is pending
        do_reset();
        send(16'hF000);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; instruction = 16'hF802;
        #1 chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        send(16'hF802);
        e = '0; e.ud = 1;
        chk("flush_suffix_undef", dut_bun(), e);

        // async reset mid-cycle discards prefix and held bundle
        do_reset();
        send(16'hF000);
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        send(16'hF802);
        chk("areset_prefix", dut_bun(), e);
        out_ready = 1'b0;
        send(16'h2305);
        chk("areset_held_pre", out_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("areset_held_valid", out_valid, 0);
        chk("areset_held_bundle", dut_bun(), 0);
        @(negedge clk) rst_n = 1'b1;

        // randomized traffic vs model
        do_reset();
        m_ov = 0; m_wait = 0; m_hi = '0; m_cnt = '0; m_b = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            flush = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            instruction = rnd_ins();
            #1;
            exp_rdy = !flush && (!m_ov || out_ready);
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, m_ov);
            chk("rnd_count", dec_count, m_cnt);
            if (m_ov) chk("rnd_bundle", dut_bun(), m_b);
            if (flush) begin
                m_ov = 0; m_wait = 0;
            end else begin
                if (m_ov && out_ready) m_cnt++;
                if (in_valid && exp_rdy) begin
                    if (!m_wait && instruction[15:11] == 5'b11110) begin
                        m_wait = 1; m_hi = instruction[10:0]; m_ov = 0;
                    end else begin
                        m_b = ref_dec(m_wait, m_hi, instruction);
                        m_ov = 1; m_wait = 0;
                    end
                end else if (out_ready) m_ov = 0;
            end
        end

        // stream NOPs to wrap the counter
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; instruction = 16'hBF00; out_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1 chk("cnt_max", dec_count, 16'hFFFF);
        @(posedge clk); #1;
        chk("cnt_wrap", dec_count, 16'h0000);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
